// File: rtl/key_command_filter_if.sv
// Command-side bundle of key_command_filter: raw key/frame inputs, the
// one-entry valid/ready command buffer and the status outputs.
interface key_command_filter_if;
  logic [7:0] keycode;
  logic       frame_vs;
  logic       cmd_ready;
  logic       cmd_valid;
  logic [1:0] cmd_dir;
  logic       cmd_walk;
  logic [1:0] facing;
  logic       key_held;

  modport master (
    output keycode, frame_vs, cmd_ready,
    input  cmd_valid, cmd_dir, cmd_walk, facing, key_held
  );

  modport slave (
    input  keycode, frame_vs, cmd_ready,
    output cmd_valid, cmd_dir, cmd_walk, facing, key_held
  );
endinterface

// File: rtl/key_command_filter.sv
// Turns raw HID keycodes into debounced turn/walk commands for the movement
// stage, delivered through a one-entry valid/ready buffer.
module key_command_filter #(
  parameter int unsigned DEBOUNCE_FRAMES = 2,
  parameter int unsigned HOLD_FRAMES     = 4
) (
  input logic                 Clk,
  input logic                 Reset_n,
  key_command_filter_if.slave kif
);

  localparam logic [3:0] DebounceCnt = 4'(DEBOUNCE_FRAMES);
  localparam logic [3:0] HoldCnt     = 4'(HOLD_FRAMES);

  typedef enum logic [1:0] {StIdle, StHold, StWalk} state_e;

  logic [7:0] kc_s1_q, kc_s2_q, kc_sync_q;
  logic       vs_s1_q, vs_s2_q, vs_s3_q;
  logic       frame_tick;

  logic       cand_present;
  logic [1:0] cand_dir;

  logic [2:0] prev_q, prev_d;
  logic [3:0] stable_q, stable_d;
  logic       acc_p_q, acc_p_d;
  logic [1:0] acc_dir_q, acc_dir_d;

  state_e     state_q, state_d;
  logic [3:0] hold_q, hold_d;
  logic       hold_inc;

  logic       cmd_valid_q, cmd_valid_d;
  logic [1:0] cmd_dir_q, cmd_dir_d;
  logic       cmd_walk_q, cmd_walk_d;
  logic [1:0] facing_q, facing_d;

  logic       can_load, load, load_walk;
  logic       same_dir;

  // The PIO may be written mid-cycle; only a value seen twice in a row is taken.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      kc_s1_q   <= '0;
      kc_s2_q   <= '0;
      kc_sync_q <= '0;
      vs_s1_q   <= 1'b0;
      vs_s2_q   <= 1'b0;
      vs_s3_q   <= 1'b0;
    end else begin
      kc_s1_q <= kif.keycode;
      kc_s2_q <= kc_s1_q;
      if (kc_s1_q == kc_s2_q) kc_sync_q <= kc_s2_q;
      vs_s1_q <= kif.frame_vs;
      vs_s2_q <= vs_s1_q;
      vs_s3_q <= vs_s2_q;
    end
  end

  assign frame_tick = vs_s3_q & ~vs_s2_q;

  always_comb begin
    cand_present = 1'b1;
    cand_dir     = 2'd0;
    case (kc_sync_q)
      8'h1A, 8'h52: cand_dir = 2'd1;
      8'h16, 8'h51: cand_dir = 2'd0;
      8'h04, 8'h50: cand_dir = 2'd2;
      8'h07, 8'h4F: cand_dir = 2'd3;
      default:      cand_present = 1'b0;
    endcase
  end

  always_comb begin
    prev_d    = prev_q;
    stable_d  = stable_q;
    acc_p_d   = acc_p_q;
    acc_dir_d = acc_dir_q;
    if (frame_tick) begin
      prev_d = {cand_present, cand_dir};
      if ({cand_present, cand_dir} == prev_q) begin
        stable_d = (stable_q == 4'hF) ? 4'hF : stable_q + 4'd1;
      end else begin
        stable_d = 4'd0;
      end
      if (stable_d == DebounceCnt) begin
        acc_p_d   = cand_present;
        acc_dir_d = cand_dir;
      end
    end
  end

  // FSM reacts to the key state being accepted this cycle, so a command
  // registers one cycle after the deciding frame_tick.
  assign can_load = ~cmd_valid_q | kif.cmd_ready;
  assign same_dir = acc_p_d & (acc_dir_d == facing_q);
  assign hold_inc = frame_tick & same_dir & (hold_q != 4'hF);

  always_comb begin
    state_d   = state_q;
    hold_d    = hold_q;
    load      = 1'b0;
    load_walk = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (acc_p_d && can_load) begin
          load = 1'b1;
          if (acc_dir_d == facing_q) begin
            load_walk = 1'b1;
            state_d   = StWalk;
          end else begin
            hold_d  = 4'd0;
            state_d = StHold;
          end
        end
      end
      StHold: begin
        if (!acc_p_d) begin
          state_d = StIdle;
        end else if (!same_dir) begin
          if (can_load) begin
            load   = 1'b1;
            hold_d = 4'd0;
          end
        end else begin
          hold_d = hold_q + {3'd0, hold_inc};
          if (hold_d >= HoldCnt && can_load) begin
            load      = 1'b1;
            load_walk = 1'b1;
            state_d   = StWalk;
          end
        end
      end
      StWalk: begin
        if (!acc_p_d) begin
          state_d = StIdle;
        end else if (!same_dir) begin
          if (can_load) begin
            load    = 1'b1;
            hold_d  = 4'd0;
            state_d = StHold;
          end
        end else if (can_load) begin
          load      = 1'b1;
          load_walk = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    cmd_valid_d = load | (cmd_valid_q & ~kif.cmd_ready);
    cmd_dir_d   = load ? acc_dir_d : cmd_dir_q;
    cmd_walk_d  = load ? load_walk : cmd_walk_q;
    facing_d    = load ? acc_dir_d : facing_q;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      prev_q      <= '0;
      stable_q    <= '0;
      acc_p_q     <= 1'b0;
      acc_dir_q   <= '0;
      state_q     <= StIdle;
      hold_q      <= '0;
      cmd_valid_q <= 1'b0;
      cmd_dir_q   <= '0;
      cmd_walk_q  <= 1'b0;
      facing_q    <= '0;
    end else begin
      prev_q      <= prev_d;
      stable_q    <= stable_d;
      acc_p_q     <= acc_p_d;
      acc_dir_q   <= acc_dir_d;
      state_q     <= state_d;
      hold_q      <= hold_d;
      cmd_valid_q <= cmd_valid_d;
      cmd_dir_q   <= cmd_dir_d;
      cmd_walk_q  <= cmd_walk_d;
      facing_q    <= facing_d;
    end
  end

  assign kif.cmd_valid = cmd_valid_q;
  assign kif.cmd_dir   = cmd_dir_q;
  assign kif.cmd_walk  = cmd_walk_q;
  assign kif.facing    = facing_q;
  assign kif.key_held  = acc_p_q;

endmodule

// File: tb/tb_key_command_filter.sv
// Directed bench for key_command_filter: expected commands are queued as the
// stimulus is driven and compared when the consumer accepts them.
module tb_key_command_filter;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [2:0] exp_q[$];

  key_command_filter_if kif ();

  key_command_filter #(
    .DEBOUNCE_FRAMES(2),
    .HOLD_FRAMES    (4)
  ) dut (
    .Clk    (clk),
    .Reset_n(rst_n),
    .kif    (kif)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  // Consumer side: every accepted command must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n && kif.cmd_valid && kif.cmd_ready) begin
      n_cmp++;
      assert (exp_q.size() > 0)
      else begin
        n_err++;
        $error("FAIL unexpected_cmd: observed {dir,walk}=%0h expected none",
               {kif.cmd_dir, kif.cmd_walk});
      end
      if (exp_q.size() > 0) begin
        logic [2:0] e;
        e = exp_q.pop_front();
        n_cmp++;
        assert ({kif.cmd_dir, kif.cmd_walk} === e)
        else begin
          n_err++;
          $error("FAIL handshake_cmd: observed {dir,walk}=%0h expected %0h",
                 {kif.cmd_dir, kif.cmd_walk}, e);
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    assert (got === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_cmd(input string tag, input logic [1:0] dir, input logic walk);
    check({tag, "_valid"}, {7'd0, kif.cmd_valid}, 8'd1);
    check({tag, "_cmd"}, {5'd0, kif.cmd_dir, kif.cmd_walk}, {5'd0, dir, walk});
  endtask

  task automatic tick_fall();
    kif.frame_vs = 1'b0;
    cyc(2);
  endtask

  task automatic tick_rise();
    kif.frame_vs = 1'b1;
    cyc(3);
  endtask

  task automatic tick();
    tick_fall();
    cyc(1);
    tick_rise();
  endtask

  task automatic pulse_ready();
    kif.cmd_ready = 1'b1;
    cyc(1);
    kif.cmd_ready = 1'b0;
  endtask

  task automatic set_key(input logic [7:0] code);
    kif.keycode = code;
    cyc(5);
  endtask

  initial begin
    n_cmp         = 0;
    n_err         = 0;
    rst_n         = 1'b0;
    kif.keycode   = 8'h00;
    kif.frame_vs  = 1'b1;
    kif.cmd_ready = 1'b0;
    cyc(3);
    check("rst_valid", {7'd0, kif.cmd_valid}, 8'd0);
    check("rst_dir", {6'd0, kif.cmd_dir}, 8'd0);
    check("rst_walk", {7'd0, kif.cmd_walk}, 8'd0);
    check("rst_facing", {6'd0, kif.facing}, 8'd0);
    check("rst_held", {7'd0, kif.key_held}, 8'd0);
    rst_n = 1'b1;
    cyc(2);

    // D held from facing down: turn after debounce, walk after the hold period.
    kif.cmd_ready = 1'b1;
    set_key(8'h07);
    tick();
    check("d_t1_valid", {7'd0, kif.cmd_valid}, 8'd0);
    tick();
    check("d_t2_valid", {7'd0, kif.cmd_valid}, 8'd0);
    exp_q.push_back({2'd3, 1'b0});
    tick_fall();
    check("d_turn_early", {7'd0, kif.cmd_valid}, 8'd0);
    cyc(1);
    check_cmd("d_turn", 2'd3, 1'b0);
    check("d_turn_facing", {6'd0, kif.facing}, 8'd3);
    check("d_turn_held", {7'd0, kif.key_held}, 8'd1);
    tick_rise();
    for (int i = 0; i < 3; i++) begin
      tick();
      check("d_hold_valid", {7'd0, kif.cmd_valid}, 8'd0);
    end
    exp_q.push_back({2'd3, 1'b1});
    tick_fall();
    check("d_walk_early", {7'd0, kif.cmd_valid}, 8'd0);
    kif.cmd_ready = 1'b0;
    cyc(1);
    check_cmd("d_walk", 2'd3, 1'b1);
    check("d_walk_facing", {6'd0, kif.facing}, 8'd3);
    tick_rise();

    // Consumer stalls for ten frames: the buffered walk must stay put.
    for (int i = 0; i < 10; i++) begin
      tick();
      check_cmd("stall", 2'd3, 1'b1);
    end
    exp_q.push_back({2'd3, 1'b1});
    pulse_ready();
    check_cmd("stall_next", 2'd3, 1'b1);

    // Asynchronous reset mid-walk with a command buffered.
    #3;
    rst_n = 1'b0;
    #1;
    check("arst_valid", {7'd0, kif.cmd_valid}, 8'd0);
    check("arst_dir", {6'd0, kif.cmd_dir}, 8'd0);
    check("arst_walk", {7'd0, kif.cmd_walk}, 8'd0);
    check("arst_facing", {6'd0, kif.facing}, 8'd0);
    check("arst_held", {7'd0, kif.key_held}, 8'd0);
    exp_q.delete();
    kif.keycode = 8'h00;
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // S held while already facing down: straight to walking.
    set_key(8'h16);
    tick();
    tick();
    check("s_t2_valid", {7'd0, kif.cmd_valid}, 8'd0);
    exp_q.push_back({2'd0, 1'b1});
    tick_fall();
    check("s_walk_early", {7'd0, kif.cmd_valid}, 8'd0);
    cyc(1);
    check_cmd("s_walk", 2'd0, 1'b1);
    tick_rise();
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back({2'd0, 1'b1});
      pulse_ready();
      check_cmd("s_walk_next", 2'd0, 1'b1);
    end

    // Release must not cancel the command still buffered.
    set_key(8'h00);
    for (int i = 0; i < 3; i++) tick();
    check_cmd("s_rel_keep", 2'd0, 1'b1);
    check("s_rel_held", {7'd0, kif.key_held}, 8'd0);
    pulse_ready();
    check("s_rel_drain", {7'd0, kif.cmd_valid}, 8'd0);
    tick();
    check("s_idle_valid", {7'd0, kif.cmd_valid}, 8'd0);

    // One-frame tap of W, then a non-direction key held.
    set_key(8'h1A);
    tick();
    set_key(8'h00);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("tap_valid", {7'd0, kif.cmd_valid}, 8'd0);
      check("tap_held", {7'd0, kif.key_held}, 8'd0);
    end
    set_key(8'h28);
    for (int i = 0; i < 4; i++) tick();
    check("enter_valid", {7'd0, kif.cmd_valid}, 8'd0);
    check("enter_held", {7'd0, kif.key_held}, 8'd0);

    // A into walking, then switch to Right while the consumer is stalled.
    exp_q.push_back({2'd2, 1'b0});
    set_key(8'h04);
    for (int i = 0; i < 3; i++) tick();
    check_cmd("a_turn", 2'd2, 1'b0);
    pulse_ready();
    check("a_turn_drain", {7'd0, kif.cmd_valid}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("a_hold_valid", {7'd0, kif.cmd_valid}, 8'd0);
    end
    exp_q.push_back({2'd2, 1'b1});
    tick();
    check_cmd("a_walk", 2'd2, 1'b1);
    set_key(8'h4F);
    exp_q.push_back({2'd3, 1'b0});
    for (int i = 0; i < 3; i++) tick();
    check_cmd("r_blocked", 2'd2, 1'b1);
    pulse_ready();
    check_cmd("r_turn", 2'd3, 1'b0);
    check("r_turn_facing", {6'd0, kif.facing}, 8'd3);
    kif.keycode = 8'h00;
    pulse_ready();
    check("r_turn_drain", {7'd0, kif.cmd_valid}, 8'd0);
    cyc(4);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("r_rel_valid", {7'd0, kif.cmd_valid}, 8'd0);
    end
    check("r_rel_held", {7'd0, kif.key_held}, 8'd0);
    check("r_rel_facing", {6'd0, kif.facing}, 8'd3);

    check("queue_empty", 8'(exp_q.size()), 8'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
